spi_slave_mode: RTL and testbench

Parametrised SPI slave and successor to the fixed mode-0 16/8-bit slave. Adds:
- selectable CPOL/CPHA and bit order;
- a real bit counter, with per-word valid strobes instead of CS-release strobes;
- multi-word bursts within one CS frame;
- a TX load handshake, SDO output enable and frame-error detection.

It sits between the MCU SPI pins and the FPGA register/command decoder. The data and command chip-selects are kept as separate channels.

---
 rtl/spi_slave_mode.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_slave_mode.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mode.sv
// SPI slave with selectable CPOL/CPHA/bit order and separate data and command chip-selects.
// Receives burst words on both channels and shifts tx_data out on the data channel.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   spi_sck         SPI clock from the MCU
//   spi_cs_data     data chip-select (active low)
//   spi_cs_cmd      command chip-select (active low)
//   spi_sdi         MOSI
//   spi_sdo         MISO, 0 unless the data channel is selected
//   spi_sdo_oe      MISO output enable
//   tx_data         next word to transmit
//   tx_load         tx_data is captured at the end of this cycle
//   rx_data         last complete data word
//   rx_valid        rx_data updated
//   cmd             last complete command word
//   cmd_valid       cmd updated
//   frame_err       CS released mid-word, or both CS low together
//   bit_cnt         bits shifted into the current word
module spi_slave_mode #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CMD_WIDTH   = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          LSB_FIRST   = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned MAXW =
    (DATA_WIDTH > CMD_WIDTH) ? DATA_WIDTH : CMD_WIDTH,
  localparam int unsigned CW = $clog2(MAXW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_data,
  input  logic                  spi_cs_cmd,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_sdo_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic [CMD_WIDTH-1:0]  cmd,
  output logic                  cmd_valid,
  output logic                  frame_err,
  output logic [CW-1:0]         bit_cnt
);

  typedef enum logic [1:0] {
    IDLE, DATA, CMD, ERR
  } state_t;

  localparam int unsigned WARM = SYNC_STAGES + 1;
  localparam int unsigned WW   = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] csd_sync;
  logic [SYNC_STAGES-1:0] csc_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sck_q;
  logic                   csd_q;
  logic                   csc_q;
  logic [WW-1:0]          warm;

  logic sck_s, csd_s, csc_s, sdi_s;
  logic live;
  logic lead, trail, sample, launch;
  logic fall_d, fall_c, rise_d, rise_c;

  state_t state, state_n;
  logic   ferr_n, load, shift_d, shift_c;
  logic   last_d, last_c;

  logic [DATA_WIDTH-1:0] rx_sr, rx_nxt;
  logic [CMD_WIDTH-1:0]  cmd_sr, cmd_nxt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic                  sdo_r;
  logic                  skip;

  function automatic logic head(
    input logic [DATA_WIDTH-1:0] v
  );
    return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] adv(
    input logic [DATA_WIDTH-1:0] v
  );
    return LSB_FIRST ? {1'b0, v[DATA_WIDTH-1:1]}
                     : {v[DATA_WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= {SYNC_STAGES{CPOL}};
      csd_sync <= '1;
      csc_sync <= '1;
      sdi_sync <= '0;
      sck_q    <= CPOL;
      csd_q    <= 1'b1;
      csc_q    <= 1'b1;
      warm     <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      csd_sync <= {csd_sync[SYNC_STAGES-2:0], spi_cs_data};
      csc_sync <= {csc_sync[SYNC_STAGES-2:0], spi_cs_cmd};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sck_q    <= sck_sync[SYNC_STAGES-1];
      csd_q    <= csd_sync[SYNC_STAGES-1];
      csc_q    <= csc_sync[SYNC_STAGES-1];
      if (!live) warm <= warm + WW'(1);
    end
  end

  // Edges are ignored until the chains have flushed their reset
  // values, so a CS already low at reset release is not a frame start.
  assign live  = (warm == WW'(WARM));
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign csd_s = csd_sync[SYNC_STAGES-1];
  assign csc_s = csc_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  assign lead   = live && (sck_s != sck_q) && (sck_s != CPOL);
  assign trail  = live && (sck_s != sck_q) && (sck_s == CPOL);
  assign sample = CPHA ? trail : lead;
  assign launch = CPHA ? lead : trail;
  assign fall_d = live && !csd_s && csd_q;
  assign fall_c = live && !csc_s && csc_q;
  assign rise_d = live && csd_s && !csd_q;
  assign rise_c = live && csc_s && !csc_q;

  assign last_d = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign last_c = (bit_cnt == CW'(CMD_WIDTH - 1));

  assign rx_nxt = LSB_FIRST ? {sdi_s, rx_sr[DATA_WIDTH-1:1]}
                            : {rx_sr[DATA_WIDTH-2:0], sdi_s};
  assign cmd_nxt = LSB_FIRST ? {sdi_s, cmd_sr[CMD_WIDTH-1:1]}
                             : {cmd_sr[CMD_WIDTH-2:0], sdi_s};

  // CS transitions are checked before SCK edges, so a CS rise
  // in the same cycle as an edge drops the edge.
  always_comb begin
    state_n = state;
    ferr_n  = 1'b0;
    load    = 1'b0;
    shift_d = 1'b0;
    shift_c = 1'b0;
    unique case (state)
      IDLE: begin
        if ((fall_d || fall_c) && !csd_s && !csc_s) begin
          state_n = ERR;
          ferr_n  = 1'b1;
        end else if (fall_d) begin
          state_n = DATA;
          load    = 1'b1;
        end else if (fall_c) begin
          state_n = CMD;
        end
      end
      DATA: begin
        if (rise_d || (csd_s && csc_s)) begin
          state_n = IDLE;
          ferr_n  = (bit_cnt != '0);
        end else if (fall_c) begin
          state_n = ERR;
          ferr_n  = 1'b1;
        end else if (sample) begin
          shift_d = 1'b1;
          load    = last_d;
        end
      end
      CMD: begin
        if (rise_c || (csd_s && csc_s)) begin
          state_n = IDLE;
          ferr_n  = (bit_cnt != '0);
        end else if (fall_d) begin
          state_n = ERR;
          ferr_n  = 1'b1;
        end else if (sample) begin
          shift_c = 1'b1;
        end
      end
      ERR: begin
        if (csd_s && csc_s) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame_err <= 1'b0;
      rx_valid  <= 1'b0;
      cmd_valid <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      cmd_sr    <= '0;
      rx_data   <= '0;
      cmd       <= '0;
      tx_sr     <= '0;
      sdo_r     <= 1'b0;
      skip      <= 1'b0;
    end else begin
      state     <= state_n;
      frame_err <= ferr_n;
      rx_valid  <= shift_d && last_d;
      cmd_valid <= shift_c && last_c;
      if (state_n != state) begin
        bit_cnt <= '0;
      end else if (shift_d) begin
        bit_cnt <= last_d ? '0 : bit_cnt + CW'(1);
      end else if (shift_c) begin
        bit_cnt <= last_c ? '0 : bit_cnt + CW'(1);
      end
      if (shift_d) rx_sr <= rx_nxt;
      if (shift_d && last_d) rx_data <= rx_nxt;
      if (shift_c) cmd_sr <= cmd_nxt;
      if (shift_c && last_c) cmd <= cmd_nxt;
      // With CPHA=0 the first bit is presented at load time; after a
      // word wrap the following launch edge must not advance again.
      if (load) begin
        if (!CPHA) begin
          sdo_r <= head(tx_data);
          tx_sr <= adv(tx_data);
          skip  <= (state == DATA);
        end else begin
          tx_sr <= tx_data;
          skip  <= 1'b0;
        end
      end else if (state == DATA && launch) begin
        if (skip) begin
          skip <= 1'b0;
        end else begin
          sdo_r <= head(tx_sr);
          tx_sr <= adv(tx_sr);
        end
      end
      if (state_n != DATA) begin
        sdo_r <= 1'b0;
        skip  <= 1'b0;
      end
    end
  end

  assign tx_load    = load;
  assign spi_sdo_oe = (state == DATA);
  assign spi_sdo    = (state == DATA) && sdo_r;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: mode 0 MSB-first and mode 3 LSB-first
// instances driven by an SPI master model, with word-level expectations.
`timescale 1ns/1ps
module tb_spi_slave_mode;

  localparam int H = 8;

  typedef struct {
    int              inst;
    bit              is_cmd;
    int              nw;
    int              tail;
    logic [3:0][15:0] w;
    logic [3:0][15:0] tx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sck, csd, csc, sdi;
  logic [1:0] sdo, oe, txl, rxv, cmdv, ferr;
  logic [15:0] txd [2];
  logic [15:0] rxd [2];
  logic [7:0]  cmdo [2];
  logic [4:0]  bc [2];

  logic [1:0] cpol_v = 2'b10;
  logic [1:0] cpha_v = 2'b10;
  logic [1:0] lsb_v  = 2'b10;

  logic [15:0] tx_tab [2][256];
  logic [7:0]  tx_ptr [2] = '{8'd0, 8'd0};
  bit          pend [2] = '{1'b0, 1'b0};

  int n_rx [2]  = '{0, 0};
  int n_cmd [2] = '{0, 0};
  int n_err [2] = '{0, 0};
  int n_txl [2] = '{0, 0};
  int n_oe [2]  = '{0, 0};
  logic [15:0] rx_log [2][256];
  logic [7:0]  cmd_log [2][256];

  logic [15:0] exp_rx [2];
  logic [7:0]  exp_cmd [2];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    txd[0] = tx_tab[0][tx_ptr[0]];
    txd[1] = tx_tab[1][tx_ptr[1]];
  end

  spi_slave_mode u0 (
    .clk(clk), .rst(rst),
    .spi_sck(sck[0]), .spi_cs_data(csd[0]),
    .spi_cs_cmd(csc[0]), .spi_sdi(sdi[0]),
    .spi_sdo(sdo[0]), .spi_sdo_oe(oe[0]),
    .tx_data(txd[0]), .tx_load(txl[0]),
    .rx_data(rxd[0]), .rx_valid(rxv[0]),
    .cmd(cmdo[0]), .cmd_valid(cmdv[0]),
    .frame_err(ferr[0]), .bit_cnt(bc[0])
  );

  spi_slave_mode #(
    .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)
  ) u1 (
    .clk(clk), .rst(rst),
    .spi_sck(sck[1]), .spi_cs_data(csd[1]),
    .spi_cs_cmd(csc[1]), .spi_sdi(sdi[1]),
    .spi_sdo(sdo[1]), .spi_sdo_oe(oe[1]),
    .tx_data(txd[1]), .tx_load(txl[1]),
    .rx_data(rxd[1]), .rx_valid(rxv[1]),
    .cmd(cmdo[1]), .cmd_valid(cmdv[1]),
    .frame_err(ferr[1]), .bit_cnt(bc[1])
  );

  // Pulse monitor; the tx word pointer advances the cycle after
  // each tx_load so the next word is presented after capture.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rxv[i]) begin
        rx_log[i][n_rx[i] % 256] = rxd[i];
        n_rx[i]++;
      end
      if (cmdv[i]) begin
        cmd_log[i][n_cmd[i] % 256] = cmdo[i];
        n_cmd[i]++;
      end
      if (ferr[i]) n_err[i]++;
      if (oe[i]) n_oe[i]++;
      if (pend[i]) begin
        tx_ptr[i] = tx_ptr[i] + 8'd1;
        pend[i] = 1'b0;
      end
      if (txl[i]) begin
        n_txl[i]++;
        pend[i] = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input int inst, input bit is_cmd,
    input int nw, input int tail,
    input logic [15:0] w0, input logic [15:0] w1,
    input logic [15:0] w2, input logic [15:0] w3,
    input logic [15:0] t0, input logic [15:0] t1,
    input logic [15:0] t2, input logic [15:0] t3);
    vec_t v;
    v.inst = inst;
    v.is_cmd = is_cmd;
    v.nw = nw;
    v.tail = tail;
    v.w = {w3, w2, w1, w0};
    v.tx = {t3, t2, t1, t0};
    return v;
  endfunction

  // Serial stream of nw full words plus `tail` bits of word nw,
  // in wire order; bit k of the result is the k-th bit on the wire.
  function automatic logic [63:0] build(
    input int i, input bit is_cmd,
    input int nw, input int tail,
    input logic [3:0][15:0] w);
    logic [63:0] s;
    int wd, nb;
    s = '0;
    wd = is_cmd ? 8 : 16;
    for (int j = 0; j <= nw; j++) begin
      nb = (j < nw) ? wd : tail;
      for (int b = 0; b < nb; b++)
        s[j*wd+b] = lsb_v[i] ? w[j][b] : w[j][wd-1-b];
    end
    return s;
  endfunction

  task automatic spi_frame(input int i, input bit is_cmd,
                           input int nbits,
                           input logic [63:0] mo,
                           output logic [63:0] mi);
    mi = '0;
    wait_clk(2);
    sdi[i] = 1'b0;
    if (is_cmd) csc[i] = 1'b0;
    else csd[i] = 1'b0;
    wait_clk(H);
    for (int k = 0; k < nbits; k++) begin
      if (!cpha_v[i]) begin
        sdi[i] = mo[k];
        wait_clk(H);
        mi[k] = sdo[i];
        sck[i] = ~cpol_v[i];
        wait_clk(H);
        sck[i] = cpol_v[i];
      end else begin
        sck[i] = ~cpol_v[i];
        sdi[i] = mo[k];
        wait_clk(H);
        mi[k] = sdo[i];
        sck[i] = cpol_v[i];
        wait_clk(H);
      end
    end
    wait_clk(H);
    if (is_cmd) csc[i] = 1'b1;
    else csd[i] = 1'b1;
    wait_clk(H);
  endtask

  task automatic toggle_bits(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      sck[i] = ~cpol_v[i];
      sdi[i] = 1'($urandom);
      wait_clk(H);
      sck[i] = cpol_v[i];
      wait_clk(H);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int i, wd, nbits;
    int r0, c0, e0, t0, o0;
    logic [7:0] base;
    logic [63:0] mo, mi, emi;
    i = v.inst;
    wd = v.is_cmd ? 8 : 16;
    nbits = v.nw * wd + v.tail;
    base = tx_ptr[i];
    for (int j = 0; j < 4; j++)
      tx_tab[i][base + 8'(j)] = v.tx[j];
    r0 = n_rx[i];
    c0 = n_cmd[i];
    e0 = n_err[i];
    t0 = n_txl[i];
    o0 = n_oe[i];
    mo = build(i, v.is_cmd, v.nw, v.tail, v.w);
    emi = build(i, 1'b0, v.nw, v.tail, v.tx);
    spi_frame(i, v.is_cmd, nbits, mo, mi);
    wait_clk(4);
    if (v.is_cmd) begin
      check("cmd_count", 64'(n_cmd[i] - c0), 64'(v.nw));
      check("rx_count_in_cmd", 64'(n_rx[i] - r0), 64'd0);
      for (int j = 0; j < v.nw; j++)
        check("cmd_word", 64'(cmd_log[i][(c0 + j) % 256]),
              64'(v.w[j][7:0]));
      if (v.nw > 0) exp_cmd[i] = v.w[v.nw-1][7:0];
      check("cmd_hold", 64'(cmdo[i]), 64'(exp_cmd[i]));
      check("tx_load_cmd", 64'(n_txl[i] - t0), 64'd0);
      check("sdo_oe_cmd", 64'(n_oe[i] - o0), 64'd0);
    end else begin
      check("rx_count", 64'(n_rx[i] - r0), 64'(v.nw));
      check("cmd_count_in_data", 64'(n_cmd[i] - c0), 64'd0);
      for (int j = 0; j < v.nw; j++)
        check("rx_word", 64'(rx_log[i][(r0 + j) % 256]),
              64'(v.w[j]));
      if (v.nw > 0) exp_rx[i] = v.w[v.nw-1];
      check("rx_hold", 64'(rxd[i]), 64'(exp_rx[i]));
      check("tx_load_data", 64'(n_txl[i] - t0), 64'(v.nw + 1));
      check("sdo_oe_data", 64'(n_oe[i] - o0 > 0), 64'd1);
      check("sdo_stream", mi, emi);
    end
    check("frame_err", 64'(n_err[i] - e0), 64'(v.tail != 0));
    check("bit_cnt_idle", 64'(bc[i]), 64'd0);
  endtask

  function automatic logic [63:0] outs(input int i);
    return 64'({rxd[i], cmdo[i], bc[i], sdo[i], oe[i],
                txl[i], rxv[i], cmdv[i], ferr[i]});
  endfunction

  vec_t vt [8];
  int r0, c0, e0, t0, o0;
  int ri, rn, rt;
  bit rc;

  initial begin
    vt[0] = mk(0, 0, 1, 0, 16'hA55A, 0, 0, 0,
               16'h3C96, 16'h0000, 0, 0);
    vt[1] = mk(1, 1, 1, 0, 16'h0081, 0, 0, 0, 0, 0, 0, 0);
    vt[2] = mk(0, 0, 3, 0, 16'h0001, 16'h8000, 16'hFFFF, 0,
               16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    vt[3] = mk(0, 0, 0, 9, 16'h5A5A, 0, 0, 0,
               16'hC3A5, 0, 0, 0);
    vt[4] = mk(1, 0, 2, 0, 16'h1234, 16'hBEEF, 0, 0,
               16'hC3A5, 16'h0F0F, 16'h8001, 0);
    vt[5] = mk(0, 1, 1, 0, 16'h005A, 0, 0, 0, 0, 0, 0, 0);
    vt[6] = mk(1, 1, 0, 3, 16'h00FF, 0, 0, 0, 0, 0, 0, 0);
    vt[7] = mk(1, 1, 2, 0, 16'h00C4, 16'h0037, 0, 0,
               0, 0, 0, 0);

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) tx_tab[i][j] = '0;
    exp_rx = '{16'h0, 16'h0};
    exp_cmd = '{8'h0, 8'h0};
    rst = 1'b1;
    sck = cpol_v;
    csd = 2'b11;
    csc = 2'b11;
    sdi = 2'b00;
    wait_clk(3);
    check("reset_outs_0", outs(0), 64'd0);
    check("reset_outs_1", outs(1), 64'd0);
    rst = 1'b0;
    wait_clk(10);

    for (int k = 0; k < 8; k++) run_vec(vt[k]);

    // Both chip-selects falling together.
    r0 = n_rx[0];
    c0 = n_cmd[0];
    e0 = n_err[0];
    t0 = n_txl[0];
    csd[0] = 1'b0;
    csc[0] = 1'b0;
    wait_clk(H);
    toggle_bits(0, 8);
    csd[0] = 1'b1;
    csc[0] = 1'b1;
    wait_clk(H);
    check("both_cs_err", 64'(n_err[0] - e0), 64'd1);
    check("both_cs_rx", 64'(n_rx[0] - r0), 64'd0);
    check("both_cs_cmd", 64'(n_cmd[0] - c0), 64'd0);
    check("both_cs_txl", 64'(n_txl[0] - t0), 64'd0);
    run_vec(mk(0, 1, 1, 0, 16'h0055, 0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a data word with CS held low.
    tx_tab[0][tx_ptr[0]] = 16'hFFFF;
    csd[0] = 1'b0;
    wait_clk(H);
    toggle_bits(0, 5);
    #2 rst = 1'b1;
    #1 check("reset_mid_0", outs(0), 64'd0);
    check("reset_mid_1", outs(1), 64'd0);
    wait_clk(3);
    rst = 1'b0;
    exp_rx = '{16'h0, 16'h0};
    exp_cmd = '{8'h0, 8'h0};
    r0 = n_rx[0];
    e0 = n_err[0];
    t0 = n_txl[0];
    o0 = n_oe[0];
    wait_clk(10);
    toggle_bits(0, 16);
    wait_clk(4);
    check("post_rst_rx", 64'(n_rx[0] - r0), 64'd0);
    check("post_rst_txl", 64'(n_txl[0] - t0), 64'd0);
    check("post_rst_oe", 64'(n_oe[0] - o0), 64'd0);
    check("post_rst_cnt", 64'(bc[0]), 64'd0);
    csd[0] = 1'b1;
    wait_clk(H);
    check("post_rst_err", 64'(n_err[0] - e0), 64'd0);
    check("post_rst_hold", 64'(rxd[0]), 64'd0);
    run_vec(mk(0, 0, 1, 0, 16'hC0DE, 0, 0, 0,
               16'h7E81, 16'h0, 0, 0));

    for (int r = 0; r < 8; r++) begin
      ri = $urandom_range(0, 1);
      rc = 1'($urandom);
      rn = $urandom_range(1, 3);
      rt = 0;
      if ($urandom_range(0, 3) == 0)
        rt = $urandom_range(1, rc ? 7 : 15);
      run_vec(mk(ri, rc, rn, rt,
                 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
